// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event strobes into fixed active-low windows with a guaranteed gap, queuing extra events
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clear,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PEND_W-1:0] pending_n;
  logic overflow_n, last, restart;
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pending_n  = pending;
    overflow_n = overflow;
    last       = cnt == CW'(1);
    restart    = (pending != '0) || pulse_in;
    case (state)
      IDLE: begin
        state_n = pulse_in ? HOLD : IDLE;
        cnt_n   = pulse_in ? CW'(HOLD_CYCLES) : cnt;
      end
      HOLD: begin
        state_n = last ? GAP : HOLD;
        cnt_n   = last ? CW'(GAP_CYCLES) : cnt - CW'(1);
      end
      GAP: begin
        state_n = !last ? GAP : restart ? HOLD : IDLE;
        cnt_n   = !last ? cnt - CW'(1) : restart ? CW'(HOLD_CYCLES) : '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    // On the final gap cycle a dequeue frees a slot, so a coincident pulse is never lost there
    if (state == GAP && last)
      pending_n = (pending == '0 || pulse_in) ? pending : pending - PEND_W'(1);
    else if (state != IDLE && pulse_in) begin
      pending_n  = (&pending) ? pending : pending + PEND_W'(1);
      overflow_n = overflow | (&pending);
    end
    if (clear) begin
      state_n    = IDLE;
      cnt_n      = '0;
      pending_n  = '0;
      overflow_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      led_out  <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pending_n;
      overflow <= overflow_n;
      led_out  <= state_n != HOLD;
      busy     <= state_n != IDLE;
    end
  end
endmodule
